alu_arbiter_seq: RTL

Sequencer and two-port arbiter that shares one 32-bit combinational ALU core between two requesters. Each requester presents an opcode, operands and a shift amount through a valid/ready handshake. The block grants one request at a time, latches the operands, evaluates them in the shared core, registers the result and the carry, zero, overflow and sign flags, and returns them with a port ID through a valid/ready response channel. It sits between the instruction-issue logic and the ALU datapath.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_core_w32.sv | 58 +++++
 rtl/alu_arbiter_seq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter/sequencer: datapath widths,
// opcode encodings and the sequencer state encoding.
package alu_pkg;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_ROL = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;
  localparam logic [3:0] OP_SNE = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core_w32.sv
// Purely combinational ALU core shared by both requester ports.
// Produces result, carry/borrow, signed overflow and an illegal-opcode flag.
module alu_core_w32
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int SHW   = alu_pkg::SHW
) (
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [SHW-1:0]   shiftValue,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [2*WIDTH-1:0] rot_ext;

  // Evaluate the selected operation; flags default to 0 for non-arithmetic ops.
  always_comb begin
    sum_ext  = {1'b0, input1} + {1'b0, input2};
    diff_ext = {1'b0, input1} - {1'b0, input2};
    // Rotating the doubled word keeps the wrapped bits in the upper half,
    // so an amount of 0 naturally returns the input unchanged.
    rot_ext  = {input1, input1} << shiftValue;
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    illegal  = opcode[3];
    case (opcode)
      OP_ADD: begin
        result   = sum_ext[WIDTH-1:0];
        carry    = sum_ext[WIDTH];
        overflow = (input1[WIDTH-1] == input2[WIDTH-1]) &&
                   (sum_ext[WIDTH-1] != input1[WIDTH-1]);
      end
      OP_SUB: begin
        result   = diff_ext[WIDTH-1:0];
        // The extra bit of the widened difference is the unsigned borrow.
        carry    = diff_ext[WIDTH];
        overflow = (input1[WIDTH-1] != input2[WIDTH-1]) &&
                   (diff_ext[WIDTH-1] != input1[WIDTH-1]);
      end
      OP_AND: result = input1 & input2;
      OP_OR:  result = input1 | input2;
      OP_SRL: result = input1 >> shiftValue;
      OP_ROL: result = rot_ext[2*WIDTH-1:WIDTH];
      OP_SRA: result = $signed(input1) >>> shiftValue;
      OP_SNE: result = {{(WIDTH-1){1'b0}}, (input1 != input2)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_seq.sv
// Two-port arbiter and sequencer sharing one ALU core.
// IDLE grants a request and latches it, EXEC registers the core outputs,
// RESP holds the response until the consumer accepts it.
// Build option: define ALU_ARB_ROUND_ROBIN_EN for round-robin tie-breaking;
// otherwise port 0 has fixed priority.
module alu_arbiter_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int SHW   = alu_pkg::SHW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0Valid,
  output logic             req0Ready,
  input  logic [3:0]       req0Opcode,
  input  logic [WIDTH-1:0] req0Input1,
  input  logic [WIDTH-1:0] req0Input2,
  input  logic [SHW-1:0]   req0Shift,
  input  logic             req1Valid,
  output logic             req1Ready,
  input  logic [3:0]       req1Opcode,
  input  logic [WIDTH-1:0] req1Input1,
  input  logic [WIDTH-1:0] req1Input2,
  input  logic [SHW-1:0]   req1Shift,
  output logic             respValid,
  input  logic             respReady,
  output logic             respPort,
  output logic [WIDTH-1:0] respResult,
  output logic             respCarry,
  output logic             respZero,
  output logic             respOverflow,
  output logic             respSign,
  output logic             respIllegal
);

  state_t           state_reg, state_next;
  logic             last_grant_reg;
  logic             grant_any;
  logic             grant_port;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [SHW-1:0]   sh_reg;
  logic             port_reg;
  logic [WIDTH-1:0] core_result;
  logic             core_carry, core_overflow, core_illegal;

  // Arbitration: pick at most one port, only while idle and out of reset.
  always_comb begin
    grant_any  = 1'b0;
    grant_port = 1'b0;
    if (state_reg == IDLE && !reset) begin
      grant_any = req0Valid | req1Valid;
      if (req0Valid && req1Valid) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
        grant_port = ~last_grant_reg;
`else
        grant_port = 1'b0;
`endif
      end else begin
        grant_port = req1Valid;
      end
    end
  end

  assign req0Ready = grant_any && !grant_port;
  assign req1Ready = grant_any && grant_port;

  // Next-state logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_any) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (respReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, grant history and operand latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      op_reg         <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      sh_reg         <= '0;
      port_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant_any) begin
        last_grant_reg <= grant_port;
        port_reg       <= grant_port;
        op_reg         <= grant_port ? req1Opcode : req0Opcode;
        a_reg          <= grant_port ? req1Input1 : req0Input1;
        b_reg          <= grant_port ? req1Input2 : req0Input2;
        sh_reg         <= grant_port ? req1Shift  : req0Shift;
      end
    end
  end

  alu_core_w32 #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_core (
    .opcode    (op_reg),
    .input1    (a_reg),
    .input2    (b_reg),
    .shiftValue(sh_reg),
    .result    (core_result),
    .carry     (core_carry),
    .overflow  (core_overflow),
    .illegal   (core_illegal)
  );

  // Response register: captured leaving EXEC, held until the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      respValid    <= 1'b0;
      respPort     <= 1'b0;
      respResult   <= '0;
      respCarry    <= 1'b0;
      respZero     <= 1'b0;
      respOverflow <= 1'b0;
      respSign     <= 1'b0;
      respIllegal  <= 1'b0;
    end else if (state_reg == EXEC) begin
      respValid    <= 1'b1;
      respPort     <= port_reg;
      respResult   <= core_result;
      respCarry    <= core_carry;
      respZero     <= (core_result == '0);
      respOverflow <= core_overflow;
      respSign     <= core_result[WIDTH-1];
      respIllegal  <= core_illegal;
    end else if (state_reg == RESP && respReady) begin
      respValid <= 1'b0;
    end
  end

endmodule
